// File: rtl/div_operand_pairer_pkg.sv
// Shared types and constants for the divider operand pairer.
package div_operand_pairer_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int ZERO_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    WAIT_A = 2'd2,
    WAIT_B = 2'd3
  } pair_state_e;

endpackage

// File: rtl/div_pair_fifo.sv
// Single-channel operand FIFO with a registered ready (not-full) flag.
module div_pair_fifo
  import div_operand_pairer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ready_q;
  logic              push;
  logic              full_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign push     = valid_i && ready_q;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
  // Extra MSB separates full (MSBs differ) from empty (MSBs equal).
  assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign ready_o = ready_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/div_operand_pairer.sv
// Pairs dividend/divisor streams into a joint offer for the divider.
// Optional DIV_ZERO_FILTER_EN drops zero-divisor pairs and counts them.
module div_operand_pairer
  import div_operand_pairer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_W-1:0]     b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_W-1:0]     dividend_data,
  output logic                  dividend_valid,
  input  logic                  dividend_ready,
  output logic [DATA_W-1:0]     divisor_data,
  output logic                  divisor_valid,
  input  logic                  divisor_ready,
  output logic [ZERO_CNT_W-1:0] zero_cnt,
  output logic                  zero_pulse
);

`ifdef DIV_ZERO_FILTER_EN
  localparam bit ZeroFilter = 1'b1;
`else
  localparam bit ZeroFilter = 1'b0;
`endif

  pair_state_e       state_q, state_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] a_head, b_head;
  logic              a_empty, b_empty;
  logic              pop, drop, retire;

  div_pair_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_a_fifo (
    .clk     (clk),
    .arst    (arst),
    .valid_i (a_valid),
    .data_i  (a_data),
    .ready_o (a_ready),
    .pop_i   (pop),
    .head_o  (a_head),
    .empty_o (a_empty)
  );

  div_pair_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_b_fifo (
    .clk     (clk),
    .arst    (arst),
    .valid_i (b_valid),
    .data_i  (b_data),
    .ready_o (b_ready),
    .pop_i   (pop),
    .head_o  (b_head),
    .empty_o (b_empty)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    pop        = 1'b0;
    drop       = 1'b0;
    retire     = 1'b0;

    unique case (state_q)
      IDLE:   retire = 1'b1;
      OFFER: begin
        retire = dividend_ready && divisor_ready;
        if (dividend_ready && !divisor_ready)      state_d = WAIT_B;
        else if (divisor_ready && !dividend_ready) state_d = WAIT_A;
      end
      WAIT_A: retire = dividend_ready;
      WAIT_B: retire = divisor_ready;
      default: retire = 1'b1;
    endcase

    // Popping only on retire keeps the outputs stable and both FIFOs in lockstep.
    if (retire) begin
      state_d = IDLE;
      if (!a_empty && !b_empty) begin
        pop  = 1'b1;
        drop = ZeroFilter && (b_head == '0);
        if (!drop) begin
          dividend_d = a_head;
          divisor_d  = b_head;
          state_d    = OFFER;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  assign dividend_data  = dividend_q;
  assign divisor_data   = divisor_q;
  assign dividend_valid = (state_q == OFFER) || (state_q == WAIT_A);
  assign divisor_valid  = (state_q == OFFER) || (state_q == WAIT_B);

`ifdef DIV_ZERO_FILTER_EN
  logic [ZERO_CNT_W-1:0] zero_cnt_q;
  logic                  zero_pulse_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      zero_cnt_q   <= '0;
      zero_pulse_q <= 1'b0;
    end else begin
      zero_pulse_q <= drop;
      if (drop && (zero_cnt_q != '1)) zero_cnt_q <= zero_cnt_q + 1'b1;
    end
  end

  assign zero_cnt   = zero_cnt_q;
  assign zero_pulse = zero_pulse_q;
`else
  assign zero_cnt   = '0;
  assign zero_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_div_operand_pairer.sv
// Directed self-checking bench for div_operand_pairer (default parameters).
module tb_div_operand_pairer;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          arst;
  logic [DW-1:0] a_data, b_data;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [DW-1:0] dividend_data, divisor_data;
  logic          dividend_valid, divisor_valid;
  logic          dividend_ready, divisor_ready;
  logic [15:0]   zero_cnt;
  logic          zero_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_operand_pairer dut (
    .clk            (clk),
    .arst           (arst),
    .a_data         (a_data),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .b_data         (b_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .dividend_data  (dividend_data),
    .dividend_valid (dividend_valid),
    .dividend_ready (dividend_ready),
    .divisor_data   (divisor_data),
    .divisor_valid  (divisor_valid),
    .divisor_ready  (divisor_ready),
    .zero_cnt       (zero_cnt),
    .zero_pulse     (zero_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change here too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input string tag, input logic [63:0] a, input logic [63:0] b);
    check({tag, "_dv"}, dividend_valid, 1'b1);
    check({tag, "_sv"}, divisor_valid, 1'b1);
    check({tag, "_dd"}, dividend_data, a);
    check({tag, "_sd"}, divisor_data, b);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dv0"}, dividend_valid, 1'b0);
    check({tag, "_sv0"}, divisor_valid, 1'b0);
  endtask

  initial begin
    arst = 1'b1;
    a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0;
    dividend_ready = 1'b0; divisor_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check_idle("rst");
    check("rst_dd", dividend_data, 64'd0);
    check("rst_sd", divisor_data, 64'd0);
    check("rst_zcnt", zero_cnt, 16'd0);
    check("rst_zpulse", zero_pulse, 1'b0);
    arst = 1'b0;
    #1;
    check("rel_a_ready_low", a_ready, 1'b0);
    step();
    check("rel_a_ready", a_ready, 1'b1);
    check("rel_b_ready", b_ready, 1'b1);

    // Single pair: push at edge N, popped at N+1, accepted at N+2
    a_data = 64'd100; b_data = 64'd7; a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check_idle("single_n");
    step();
    check_pair("single", 64'd100, 64'd7);
    dividend_ready = 1'b1; divisor_ready = 1'b1;
    step();
    check_idle("single_done");

    // Skewed inputs (readies stay high)
    a_valid = 1'b1;
    a_data = 64'd10; step();
    a_data = 64'd20; step();
    a_data = 64'd30; step();
    a_valid = 1'b0;
    repeat (5) step();
    check_idle("skew_wait");
    b_valid = 1'b1; b_data = 64'd2;
    step();
    check_idle("skew_b0");
    b_data = 64'd4;
    step();
    check_pair("skew1", 64'd10, 64'd2);
    b_data = 64'd6;
    step();
    check_pair("skew2", 64'd20, 64'd4);
    b_valid = 1'b0;
    step();
    check_pair("skew3", 64'd30, 64'd6);
    step();
    check_idle("skew_end");

    // Split ready with a second pair waiting
    dividend_ready = 1'b0; divisor_ready = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 64'd5; b_data = 64'd3; step();
    a_data = 64'd6; b_data = 64'd4; step();
    a_valid = 1'b0; b_valid = 1'b0;
    check_pair("split_offer", 64'd5, 64'd3);
    dividend_ready = 1'b1;
    step();
    check("split_k_dv", dividend_valid, 1'b0);
    check("split_k_sv", divisor_valid, 1'b1);
    check("split_k_sd", divisor_data, 64'd3);
    step(); step();
    check("split_k2_dv", dividend_valid, 1'b0);
    check("split_k2_sv", divisor_valid, 1'b1);
    check("split_k2_sd", divisor_data, 64'd3);
    dividend_ready = 1'b0; divisor_ready = 1'b1;
    step();
    check_pair("split_next", 64'd6, 64'd4);
    dividend_ready = 1'b1;
    step();
    check_idle("split_end");

    // Full FIFO backpressure, then drain without loss
    dividend_ready = 1'b0; divisor_ready = 1'b0;
    a_valid = 1'b1;
    a_data = 64'd1; step();
    a_data = 64'd2; step();
    a_data = 64'd3; step();
    a_data = 64'd4; step();
    check("full_a_ready", a_ready, 1'b0);
    check("full_b_ready", b_ready, 1'b1);
    a_data = 64'd5;
    step();
    check("full_held", a_ready, 1'b0);
    check_idle("full_no_b");
    b_valid = 1'b1; b_data = 64'd11;
    step();
    b_data = 64'd12;
    step();
    check_pair("drain1", 64'd1, 64'd11);
    check("drain_a_ready", a_ready, 1'b1);
    dividend_ready = 1'b1; divisor_ready = 1'b1; b_data = 64'd13;
    step();
    check_pair("drain2", 64'd2, 64'd12);
    a_valid = 1'b0; b_data = 64'd14;
    step();
    check_pair("drain3", 64'd3, 64'd13);
    b_data = 64'd15;
    step();
    check_pair("drain4", 64'd4, 64'd14);
    b_valid = 1'b0;
    step();
    check_pair("drain5", 64'd5, 64'd15);
    step();
    check_idle("drain_end");

    // Zero-divisor pair followed by a normal pair (readies high)
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 64'd9; b_data = 64'd0; step();
    a_data = 64'd9; b_data = 64'd3; step();
    a_valid = 1'b0; b_valid = 1'b0;
`ifdef DIV_ZERO_FILTER_EN
    check_idle("zero_drop");
    check("zero_pulse_hi", zero_pulse, 1'b1);
    check("zero_cnt1", zero_cnt, 16'd1);
    step();
    check_pair("zero_keep", 64'd9, 64'd3);
    check("zero_pulse_lo", zero_pulse, 1'b0);
    check("zero_cnt_hold", zero_cnt, 16'd1);
`else
    check_pair("zero_pass", 64'd9, 64'd0);
    check("zero_pulse_tied", zero_pulse, 1'b0);
    step();
    check_pair("zero_keep", 64'd9, 64'd3);
    check("zero_cnt_tied", zero_cnt, 16'd0);
`endif
    step();
    check_idle("zero_end");

    // Reset while in WAIT_B with two entries buffered
    dividend_ready = 1'b0; divisor_ready = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 64'd1; b_data = 64'd1; step();
    a_data = 64'd2; b_data = 64'd2; step();
    a_data = 64'd3; b_data = 64'd3; step();
    a_valid = 1'b0; b_valid = 1'b0;
    dividend_ready = 1'b1;
    step();
    check("wb_sv", divisor_valid, 1'b1);
    check("wb_dv", dividend_valid, 1'b0);
    arst = 1'b1;
    #1;
    check_idle("arst_mid");
    check("arst_mid_a_ready", a_ready, 1'b0);
    check("arst_mid_dd", dividend_data, 64'd0);
    step();
    arst = 1'b0;
    dividend_ready = 1'b1; divisor_ready = 1'b1;
    step(); step(); step();
    check_idle("post_rst_empty");
    check("post_rst_a_ready", a_ready, 1'b1);
    dividend_ready = 1'b0; divisor_ready = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 64'd77; b_data = 64'd88;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check_pair("post_rst_fresh", 64'd77, 64'd88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
